// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// well-known command bytes and cycle-count helpers derived from the clock rate.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_DATA,
        ST_ACK,
        ST_WAITIDLE,
        ST_ERR
    } txState_t;

    localparam logic [7:0] PS2_CMD_LED   = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
    localparam logic [7:0] PS2_ACK       = 8'hFA;

    // 64-bit product so that large clock rates times long intervals cannot overflow.
    function automatic int unsigned usToCycles(input int unsigned clkHz, input int unsigned us);
        logic [63:0] prod;
        prod = {32'd0, clkHz} * {32'd0, us};
        prod = prod / 64'd1000000;
        return prod[31:0];
    endfunction

    function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Two-flop synchroniser plus a run-length filter for one raw PS/2 pin.
// The filtered level only moves after FILTER_LEN consecutive agreeing samples.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // Idle bus is high, so everything resets to 1 to avoid a spurious fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_line};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then
// shifts one command byte out on device clock falls and checks the ack bit.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned INHIBIT_US  = 120,
    parameter int unsigned START_TO_MS = 15,
    parameter int unsigned FRAME_TO_MS = 2,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);

    localparam int unsigned INHIBIT_CYC = usToCycles(CLK_HZ, INHIBIT_US);
    localparam int unsigned START_CYC   = usToCycles(CLK_HZ, START_TO_MS * 1000);
    localparam int unsigned FRAME_CYC   = usToCycles(CLK_HZ, FRAME_TO_MS * 1000);
    localparam int unsigned MAX_CYC     = maxOf(maxOf(INHIBIT_CYC, START_CYC), FRAME_CYC);
    localparam int unsigned TIMER_W     = $clog2(MAX_CYC + 1);

    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYC - 1);
    localparam logic [TIMER_W-1:0] INHIBIT_PEN  = TIMER_W'(INHIBIT_CYC - 2);
    localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_CYC - 1);
    localparam logic [TIMER_W-1:0] FRAME_LAST   = TIMER_W'(FRAME_CYC - 1);

    txState_t           r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [3:0]         r_bitCnt;
    logic [8:0]         r_shift;
    logic               r_ackOk;
    logic               r_clkPrev;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic               r_clkOe;
    logic               r_dataOe;

    logic               w_clkLevel;
    logic               w_dataLevel;
    logic               w_clkFall;
    logic               w_timeout;
    logic [TIMER_W-1:0] w_timerNext;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clkFilter (
        .clk     (clk),
        .rst     (rst),
        .i_line  (ps2clk_in),
        .o_level (w_clkLevel)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dataFilter (
        .clk     (clk),
        .rst     (rst),
        .i_line  (ps2data_in),
        .o_level (w_dataLevel)
    );

    assign w_clkFall   = r_clkPrev & ~w_clkLevel;
    assign w_timerNext = (r_timer == '1) ? r_timer : r_timer + TIMER_W'(1);
    // Checked ahead of the state logic so a timeout beats a coincident clock fall.
    assign w_timeout   = ((r_state == ST_REQ) && (r_timer == START_LAST)) ||
                         (((r_state == ST_DATA) || (r_state == ST_ACK) ||
                           (r_state == ST_WAITIDLE)) && (r_timer == FRAME_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_ackOk   <= 1'b0;
            r_clkPrev <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_clkOe   <= 1'b0;
            r_dataOe  <= 1'b0;
        end else begin
            r_clkPrev <= w_clkLevel;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            if (w_timeout) begin
                r_clkOe  <= 1'b0;
                r_dataOe <= 1'b0;
                r_state  <= ST_ERR;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (tx_valid && r_ready) begin
                            r_shift  <= {~^tx_data, tx_data};
                            r_timer  <= '0;
                            r_bitCnt <= '0;
                            r_clkOe  <= 1'b1;
                            r_busy   <= 1'b1;
                            r_ready  <= 1'b0;
                            r_state  <= ST_INHIBIT;
                        end
                    end
                    // The start bit goes out in the final inhibit cycle.
                    ST_INHIBIT: begin
                        if (r_timer == INHIBIT_LAST) begin
                            r_clkOe <= 1'b0;
                            r_timer <= '0;
                            r_state <= ST_REQ;
                        end else begin
                            r_timer <= w_timerNext;
                            if (r_timer == INHIBIT_PEN) begin
                                r_dataOe <= 1'b1;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (w_clkFall) begin
                            r_dataOe <= ~r_shift[0];
                            r_shift  <= r_shift >> 1;
                            r_bitCnt <= 4'd1;
                            r_timer  <= '0;
                            r_state  <= ST_DATA;
                        end else begin
                            r_timer <= w_timerNext;
                        end
                    end
                    // Shift register holds data then parity; fall 10 releases for stop.
                    ST_DATA: begin
                        r_timer <= w_timerNext;
                        if (w_clkFall) begin
                            r_bitCnt <= r_bitCnt + 4'd1;
                            if (r_bitCnt == 4'd9) begin
                                r_dataOe <= 1'b0;
                                r_state  <= ST_ACK;
                            end else begin
                                r_dataOe <= ~r_shift[0];
                                r_shift  <= r_shift >> 1;
                            end
                        end
                    end
                    ST_ACK: begin
                        r_timer <= w_timerNext;
                        if (w_clkFall) begin
                            r_bitCnt <= r_bitCnt + 4'd1;
                            r_ackOk  <= ~w_dataLevel;
                            r_state  <= ST_WAITIDLE;
                        end
                    end
                    ST_WAITIDLE: begin
                        r_timer <= w_timerNext;
                        if (w_clkLevel && w_dataLevel) begin
                            r_done  <= r_ackOk;
                            r_error <= ~r_ackOk;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_ERR: begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready   = r_ready;
    assign busy       = r_busy;
    assign tx_done    = r_done;
    assign tx_error   = r_error;
    assign ps2clk_oe  = r_clkOe;
    assign ps2data_oe = r_dataOe;

endmodule
